// File: rtl/readout_stream.sv
// Drains the readout DPRAM after each readout cycle: tracks the readout window,
// waits for the valid strobe, sweeps every address once and emits present entries.
module readout_stream #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  readoutActive,
  input  logic                  readoutValid,
  output logic [ADDR_WIDTH-1:0] readoutAddress,
  input  logic [DATA_WIDTH-1:0] readoutData,
  input  logic                  readoutPresent,
  output logic [ADDR_WIDTH-1:0] packetIndex,
  output logic [DATA_WIDTH-1:0] packetData,
  output logic                  packetValid,
  output logic [2:0]            state
);

  // Handshake: readoutValid is sampled only in WAIT_VALID (level or pulse);
  // packetValid qualifies packetIndex/packetData for exactly one cycle, no backpressure.

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ACTIVE     = 3'd1,
    S_WAIT_VALID = 3'd2,
    S_STREAM     = 3'd3,
    S_DRAIN      = 3'd4
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]         TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  state_t                cur;
  logic [CW-1:0]         tmo_cnt;
  logic                  drain_cnt;
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_addr;

  assign state = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur            <= S_IDLE;
      readoutAddress <= '0;
      tmo_cnt        <= '0;
      drain_cnt      <= 1'b0;
    end else begin
      case (cur)
        S_IDLE: begin
          readoutAddress <= '0;
          tmo_cnt        <= '0;
          if (readoutActive) cur <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (!readoutActive) begin
            cur     <= S_WAIT_VALID;
            tmo_cnt <= '0;
          end
        end
        S_WAIT_VALID: begin
          // Valid wins over a re-opened window and over the timeout.
          if (readoutValid) begin
            cur            <= S_STREAM;
            readoutAddress <= '0;
          end else if (readoutActive) begin
            cur <= S_ACTIVE;
          end else if (tmo_cnt == TMO_LAST) begin
            cur     <= S_IDLE;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        S_STREAM: begin
          readoutAddress <= readoutAddress + ADDR_WIDTH'(1);
          if (readoutAddress == ADDR_LAST) begin
            cur       <= S_DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) cur <= S_IDLE;
        end
        default: cur <= S_IDLE;
      endcase
    end
  end

  // Two-stage pipeline matching the DPRAM's one-cycle registered read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid <= 1'b0;
      issue_addr  <= '0;
      packetIndex <= '0;
      packetData  <= '0;
      packetValid <= 1'b0;
    end else begin
      issue_valid <= (cur == S_STREAM);
      issue_addr  <= readoutAddress;
      packetIndex <= issue_addr;
      packetData  <= readoutData;
      packetValid <= issue_valid & readoutPresent;
    end
  end

endmodule

// File: tb/tb_readout_stream.sv
// Bench for readout_stream: DPRAM model, table of sweep scenarios, random sweeps
// against a list-of-present-entries model, and directed timing/reset sequences.
module tb_readout_stream;
  localparam int AW = 9, DW = 32, TMO = 64, DEPTH = 512, W = AW + DW;

  logic          clk = 1'b0;
  logic          reset, readoutActive, readoutValid, readoutPresent, packetValid;
  logic [AW-1:0] readoutAddress, packetIndex;
  logic [DW-1:0] readoutData, packetData;
  logic [2:0]    state;

  always #5 clk = ~clk;

  readout_stream #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .readoutActive(readoutActive), .readoutValid(readoutValid),
    .readoutAddress(readoutAddress), .readoutData(readoutData), .readoutPresent(readoutPresent),
    .packetIndex(packetIndex), .packetData(packetData), .packetValid(packetValid), .state(state)
  );

  logic [DW-1:0] mem [DEPTH];
  logic          pres[DEPTH];

  always @(posedge clk) begin
    readoutData    <= mem[readoutAddress];
    readoutPresent <= pres[readoutAddress];
  end

  int          n_cmp = 0, n_bad = 0;
  longint      cyc = 0;
  longint      issue_cyc[DEPTH];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard capture plus address-to-packet latency on every emitted word.
  always @(negedge clk) begin
    if (state == 3'd3) issue_cyc[readoutAddress] = cyc;
    if (packetValid === 1'b1) begin
      got_q.push_back({packetIndex, packetData});
      check("latency", 64'(cyc - issue_cyc[packetIndex]), 64'd2);
    end
  end

  task automatic fill(int lo, int hi);
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = (i >= lo && i <= hi) ? (32'h0800 | 32'(i)) : '0;
      pres[i] = (mem[i] != 0);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = $urandom;
      pres[i] = ($urandom_range(0, 7) == 0);
    end
  endtask

  // Model: a sweep emits every present entry in address order; a timeout emits nothing.
  task automatic build_exp(bit swept);
    exp_q.delete();
    if (swept)
      for (int i = 0; i < DEPTH; i++)
        if (pres[i]) exp_q.push_back({AW'(i), mem[i]});
  endtask

  task automatic wait_idle(string name);
    int k = 0;
    @(negedge clk);
    while (state != 3'd0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({name, " idle"}, 64'(state), 64'd0);
  endtask

  task automatic compare(string name, int exp_cnt);
    int n;
    check({name, " count"}, 64'(got_q.size()), 64'(exp_cnt));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check({name, " pkt"}, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic open_window(int active_len);
    @(posedge clk);
    #1 readoutActive = 1'b1;
    repeat (active_len) @(posedge clk);
    #1 readoutActive = 1'b0;
  endtask

  task automatic sweep_tail(int gap, string name, int exp_cnt);
    repeat (gap) @(posedge clk);
    #1 readoutValid = 1'b1;
    @(posedge clk);
    wait_idle(name);
    repeat (4) @(posedge clk);
    #1 readoutValid = 1'b0;
    compare(name, exp_cnt);
  endtask

  typedef struct {
    int active_len;
    int gap;
    int lo;
    int hi;
    int exp_cnt;
  } vec_t;

  vec_t vecs[6] = '{
    '{10, 1,  'h20,  'h5F,  64},
    '{3,  64, 'h00,  'h03,  4},
    '{5,  65, 'h10,  'h1F,  0},
    '{1,  1,  'h1F0, 'h1FF, 16},
    '{7,  30, 'h00,  'h1FF, 512},
    '{10, 0,  'h100, 'h100, 1}
  };

  initial begin
    int bad, k, gap, alen;
    reset = 1'b0; readoutActive = 1'b0; readoutValid = 1'b0;
    fill(1, 0);
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", 64'({state, readoutAddress, packetIndex, packetData, packetValid}), 64'd0);
    @(negedge clk) reset = 1'b1;

    foreach (vecs[i]) begin
      fill(vecs[i].lo, vecs[i].hi);
      build_exp(vecs[i].exp_cnt != 0);
      got_q.delete();
      open_window(vecs[i].active_len);
      sweep_tail(vecs[i].gap, $sformatf("vec%0d", i), vecs[i].exp_cnt);
    end

    for (int r = 0; r < 6; r++) begin
      fill_random();
      alen = $urandom_range(1, 20);
      gap  = $urandom_range(1, 70);
      build_exp(gap <= TMO);
      got_q.delete();
      open_window(alen);
      sweep_tail(gap, $sformatf("rand%0d", r), exp_q.size());
    end

    // Valid held high after a completed sweep must not restart it.
    fill('h20, 'h5F);
    build_exp(1'b1);
    got_q.delete();
    open_window(10);
    sweep_tail(1, "normal", 64);
    got_q.delete();
    #1 readoutValid = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (packetValid !== 1'b0 || state !== 3'd0) bad++;
    end
    check("held_valid", 64'(bad), 64'd0);
    check("held_valid pkts", 64'(got_q.size()), 64'd0);
    readoutValid = 1'b0;

    // Timeout boundary: WAIT_VALID for exactly TMO cycles, then IDLE.
    got_q.delete();
    open_window(10);
    @(posedge clk);
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk) check("tmo_wait_last", 64'(state), 64'd2);
    @(posedge clk);
    @(negedge clk) check("tmo_idle", 64'(state), 64'd0);
    check("tmo_pkts", 64'(got_q.size()), 64'd0);
    reset = 1'b0;
    #1 check("tmo_reset_outputs", 64'({state, readoutAddress, packetIndex, packetData, packetValid}), 64'd0);
    @(negedge clk) reset = 1'b1;

    // Mid-sweep reset at address 0x30.
    fill('h20, 'h5F);
    open_window(10);
    @(posedge clk);
    #1 readoutValid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!(state == 3'd3 && readoutAddress == AW'('h30)) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("reach_0x30", 64'(readoutAddress), 64'h30);
    reset = 1'b0;
    #1 check("midreset_outputs", 64'({state, readoutAddress, packetIndex, packetData, packetValid}), 64'd0);
    got_q.delete();
    readoutValid = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (600) @(posedge clk);
    check("midreset_pkts", 64'(got_q.size()), 64'd0);
    check("midreset_state", 64'(state), 64'd0);

    // Re-arm: window re-opens during WAIT_VALID, then one full sweep.
    fill('h40, 'h47);
    build_exp(1'b1);
    got_q.delete();
    open_window(10);
    repeat (5) @(posedge clk);
    @(negedge clk) check("rearm_wait", 64'(state), 64'd2);
    @(posedge clk);
    #1 readoutActive = 1'b1;
    @(posedge clk);
    @(negedge clk) check("rearm_active", 64'(state), 64'd1);
    readoutActive = 1'b0;
    sweep_tail(3, "rearm", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
